// File: rtl/hazard5_fetch.sv
// Hazard5 instruction fetch frontend: pipelined bus master, prefetch FIFO and 3-halfword CIR.
// Optional macro HAZARD5_FETCH_BYPASS_EN lets a kept beat skip an empty FIFO straight into CIR.
module hazard5_fetch #(
  parameter int                W_ADDR       = 32,
  parameter logic [W_ADDR-1:0] RESET_VECTOR = '0,
  parameter int                FIFO_DEPTH   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [W_ADDR-1:0] o_mem_addr,
  output logic              o_mem_addr_vld,
  input  logic              i_mem_addr_rdy,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_rdata_vld,
  output logic [31:0]       o_fd_cir,
  output logic [1:0]        o_fd_cir_vld,
  input  logic [1:0]        i_df_cir_use,
  input  logic              i_d_jump_req,
  input  logic [W_ADDR-1:0] i_d_jump_target,
  input  logic              i_x_jump_req,
  input  logic [W_ADDR-1:0] i_x_jump_target,
  output logic              o_f_jump_rdy,
  output logic              o_f_jump_now,
  output logic [W_ADDR-1:0] o_f_jump_target
);

  localparam int W_CNT = 8;

  logic              r_run;
  logic              r_jump_pending;
  logic              r_skip_half;
  logic [W_ADDR-1:0] r_pc;
  logic [W_CNT-1:0]  r_inflight;
  logic [W_CNT-1:0]  r_discard;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [1:0]        r_rptr;
  logic [1:0]        r_wptr;
  logic [2:0]        r_level;
  logic [47:0]       r_cir;
  logic [1:0]        r_cir_cnt;

  logic              w_jump_rdy;
  logic              w_jump_now;
  logic [W_ADDR-1:0] w_jump_target;
  logic [W_CNT-1:0]  w_nd_inflight;
  logic              w_addr_vld;
  logic              w_addr_acc;
  logic              w_beat_drop;
  logic              w_beat_keep;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_bypass;
  logic              w_append_valid;
  logic [31:0]       w_append_word;
  logic [31:0]       w_append_half;
  logic [1:0]        w_cnt_used;
  logic [47:0]       w_cir_shift;
  logic [47:0]       w_cir_next;
  logic [1:0]        w_cnt_next;
  logic              w_unused;

  function automatic logic [1:0] ptrInc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_jump_rdy    = !i_x_jump_req && !r_jump_pending;
  assign w_jump_now    = i_x_jump_req || (i_d_jump_req && w_jump_rdy);
  assign w_jump_target = i_x_jump_req ? i_x_jump_target : i_d_jump_target;
  assign w_unused      = w_jump_target[0];

  // Discarded beats still occupy the bus but never land, so they do not count against FIFO space.
  assign w_nd_inflight = r_inflight - r_discard;
  assign w_addr_vld    = r_run && (((W_CNT'(r_level) + w_nd_inflight) < W_CNT'(FIFO_DEPTH))
                                   || r_jump_pending);
  assign w_addr_acc    = w_addr_vld && i_mem_addr_rdy;

  assign w_beat_drop   = i_mem_rdata_vld && (r_discard != '0);
  assign w_beat_keep   = i_mem_rdata_vld && (r_discard == '0) && !w_jump_now;
  assign w_fifo_empty  = (r_level == 3'd0);

  assign w_cnt_used    = r_cir_cnt - i_df_cir_use;
  assign w_cir_shift   = r_cir >> {i_df_cir_use, 4'b0000};
  assign w_pop         = (w_cnt_used <= 2'd1) && !w_fifo_empty;

`ifdef HAZARD5_FETCH_BYPASS_EN
  assign w_bypass      = w_beat_keep && w_fifo_empty && (w_cnt_used <= 2'd1);
`else
  assign w_bypass      = 1'b0;
`endif

  assign w_push         = w_beat_keep && !w_bypass;
  assign w_append_valid = w_pop || w_bypass;
  assign w_append_word  = w_pop ? r_fifo[r_rptr] : i_mem_rdata;

  always_comb begin
    w_cir_next    = w_cir_shift;
    w_cnt_next    = w_cnt_used;
    w_append_half = r_skip_half ? {16'h0000, w_append_word[31:16]} : w_append_word;
    if (w_append_valid) begin
      if (w_cnt_used == 2'd0) w_cir_next[31:0]  = w_append_half;
      else                    w_cir_next[47:16] = w_append_half;
      w_cnt_next = w_cnt_used + (r_skip_half ? 2'd1 : 2'd2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_fifo[r_wptr] <= i_mem_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run          <= 1'b0;
      r_jump_pending <= 1'b0;
      r_skip_half    <= 1'b0;
      r_pc           <= RESET_VECTOR;
      r_inflight     <= '0;
      r_discard      <= '0;
      r_rptr         <= 2'd0;
      r_wptr         <= 2'd0;
      r_level        <= 3'd0;
      r_cir          <= '0;
      r_cir_cnt      <= 2'd0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= r_inflight + W_CNT'(w_addr_acc) - W_CNT'(i_mem_rdata_vld);
      if (w_jump_now) begin
        // Everything still on the bus after this edge is stale, including a request accepted now.
        r_discard      <= r_inflight + W_CNT'(w_addr_acc) - W_CNT'(i_mem_rdata_vld);
        r_pc           <= {w_jump_target[W_ADDR-1:2], 2'b00};
        r_skip_half    <= w_jump_target[1];
        r_jump_pending <= !w_addr_acc;
        r_rptr         <= 2'd0;
        r_wptr         <= 2'd0;
        r_level        <= 3'd0;
        r_cir          <= '0;
        r_cir_cnt      <= 2'd0;
      end else begin
        if (w_beat_drop) r_discard <= r_discard - W_CNT'(1);
        if (w_addr_acc) begin
          r_pc           <= r_pc + W_ADDR'(4);
          r_jump_pending <= 1'b0;
        end
        if (w_push) r_wptr <= ptrInc(r_wptr);
        if (w_pop)  r_rptr <= ptrInc(r_rptr);
        r_level   <= r_level + 3'(w_push) - 3'(w_pop);
        r_cir     <= w_cir_next;
        r_cir_cnt <= w_cnt_next;
        if (w_append_valid) r_skip_half <= 1'b0;
      end
    end
  end

  assign o_mem_addr      = r_pc;
  assign o_mem_addr_vld  = w_addr_vld;
  assign o_fd_cir        = r_cir[31:0];
  assign o_fd_cir_vld    = (r_cir_cnt == 2'd3) ? 2'd2 : r_cir_cnt;
  assign o_f_jump_rdy    = w_jump_rdy;
  assign o_f_jump_now    = w_jump_now;
  assign o_f_jump_target = w_jump_target;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_push && (r_level == 3'(FIFO_DEPTH))));
      assert (i_df_cir_use <= o_fd_cir_vld);
    end
  end

endmodule
